ula_seq_ctrl: RTL

Multi-cycle sequencer that runs wide-word operations through one shared `ula_8_bits` instance, one byte per cycle, least significant byte first. The carry is chained between passes the same way the ALU's internal 4-bit slices ripple. It sits between a valid/ready command source and the 8-bit ALU, and returns a `NBYTES*8`-bit result with the combined status flags.

---
 rtl/ula_seq_pkg.sv | 24 ++
 rtl/ula_seq_ctrl_if.sv | 52 +++++
 rtl/ula_8_bits.sv | 72 +++++++
 rtl/ula_seq_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ula_seq_pkg.sv
// rtl/ula_seq_pkg.sv - shared types and constants for the byte-serial ALU sequencer
//
// Purpose: sequencer state encoding, ALU function/mode codes and the index
// width helper used by ula_seq_ctrl and ula_8_bits.
// Ports: none (package).
package ula_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } ula_seq_state_t;

   localparam logic [3:0] ULA_S_ADD   = 4'b0101;  // A + B + Cin
   localparam logic [3:0] ULA_S_SUB   = 4'b1000;  // A - B, carry acts as borrow
   localparam logic       ULA_M_ARITH = 1'b0;
   localparam logic       ULA_M_LOGIC = 1'b1;

   // Byte index width; a single-byte word still needs one index bit.
   function automatic int seq_idx_width(input int nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/ula_seq_ctrl_if.sv
// rtl/ula_seq_ctrl_if.sv - command/response bundle between a command source and ula_seq_ctrl
//
// Purpose: groups the request handshake, operands, response handshake and
// status of the sequencer.
// Ports (signals): req_valid/req_ready, req_a/req_b (W bits), req_s, req_m,
// req_cin, rsp_valid/rsp_ready, rsp_f (W bits), rsp_eq, rsp_cout,
// rsp_overflow, busy, and rsp_zero when ULA_SEQ_ZERO_EN is defined.
// Modports: master = command source / result consumer, slave = sequencer.
interface ula_seq_ctrl_if #(
   parameter int NBYTES = 2
);
   localparam int W = 8 * NBYTES;

   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic [3:0]   req_s;
   logic         req_m;
   logic         req_cin;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_f;
   logic         rsp_eq;
   logic         rsp_cout;
   logic         rsp_overflow;
   logic         busy;
`ifdef ULA_SEQ_ZERO_EN
   logic         rsp_zero;

   modport master (
      output req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_f, rsp_eq, rsp_cout, rsp_overflow, busy, rsp_zero
   );

   modport slave (
      input  req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_f, rsp_eq, rsp_cout, rsp_overflow, busy, rsp_zero
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_f, rsp_eq, rsp_cout, rsp_overflow, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_s, req_m, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_f, rsp_eq, rsp_cout, rsp_overflow, busy
   );
`endif

endinterface

// File: rtl/ula_8_bits.sv
// rtl/ula_8_bits.sv - 8-bit combinational ALU built from two rippling 4-bit slices
//
// Purpose: one byte of arithmetic or logic per evaluation.
// Ports: a, b (8) operands; s (4) function; m mode (0 arith, 1 logic);
// c_in carry/borrow in; f (8) result; c_out carry/borrow out;
// a_eq_b operands equal; overflow signed overflow (arith only).
module ula_8_bits
   import ula_seq_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       c_in,
   output logic [7:0] f,
   output logic       c_out,
   output logic       a_eq_b,
   output logic       overflow
);

   logic [7:0] b_eff;
   logic       c0;
   logic [4:0] lo;
   logic [4:0] hi;

   always_comb begin
      f        = 8'h00;
      c_out    = c_in;
      overflow = 1'b0;
      b_eff    = 8'h00;
      c0       = c_in;
      lo       = 5'd0;
      hi       = 5'd0;
      a_eq_b   = (a == b);

      if (m == ULA_M_ARITH) begin
         case (s)
            ULA_S_ADD: begin
               b_eff = b;
               c0    = c_in;
            end
            // Subtract as A + ~B + 1 with the carry inverted on both ends,
            // so c_in/c_out behave as borrow and bytes chain correctly.
            ULA_S_SUB: begin
               b_eff = ~b;
               c0    = ~c_in;
            end
            default: begin
               b_eff = 8'h00;
               c0    = c_in;
            end
         endcase
         lo       = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0000, c0};
         hi       = {1'b0, a[7:4]} + {1'b0, b_eff[7:4]} + {4'b0000, lo[4]};
         f        = {hi[3:0], lo[3:0]};
         c_out    = (s == ULA_S_SUB) ? ~hi[4] : hi[4];
         overflow = (a[7] == b_eff[7]) && (f[7] != a[7]);
      end else begin
         case (s)
            4'b0000: f = ~a;
            4'b0011: f = 8'h00;
            4'b0110: f = a ^ b;
            4'b1011: f = a & b;
            4'b1100: f = 8'hFF;
            4'b1110: f = a | b;
            4'b1111: f = a;
            default: f = ~(a | b);
         endcase
      end
   end

endmodule

// File: rtl/ula_seq_ctrl.sv
// rtl/ula_seq_ctrl.sv - byte-serial wide-word sequencer around one ula_8_bits
//
// Purpose: accepts a W-bit command, runs it through the 8-bit ALU one byte
// per cycle (LSB first) chaining the carry, and returns the W-bit result
// with combined flags. Optional macro ULA_SEQ_ZERO_EN adds rsp_zero.
// Ports: clk, rst (async, active-high); bus (ula_seq_ctrl_if.slave):
// req_* command handshake and operands, rsp_* result handshake and flags, busy.
module ula_seq_ctrl
   import ula_seq_pkg::*;
#(
   parameter int NBYTES = 2
) (
   input  logic           clk,
   input  logic           rst,
   ula_seq_ctrl_if.slave  bus
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = seq_idx_width(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   ula_seq_state_t state;
   ula_seq_state_t state_nxt;

   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [3:0]    s_reg;
   logic          m_reg;
   logic [IW-1:0] idx;
   logic          carry;
   logic          eq_acc;
   logic [W-1:0]  f_reg;
   logic          cout_reg;
   logic          ovf_reg;

   logic          accept;
   logic          ready_c;
   logic          valid_c;
   logic          busy_c;

   // Bit offset of the current byte; idx width plus 3 always spans W.
   logic [IW+2:0] bit_off;
   assign bit_off = {idx, 3'b000};

   logic [7:0] alu_f;
   logic       alu_cout;
   logic       alu_eq;
   logic       alu_ovf;

   ula_8_bits u_alu (
      .a        (a_reg[bit_off +: 8]),
      .b        (b_reg[bit_off +: 8]),
      .s        (s_reg),
      .m        (m_reg),
      .c_in     (carry),
      .f        (alu_f),
      .c_out    (alu_cout),
      .a_eq_b   (alu_eq),
      .overflow (alu_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      valid_c   = 1'b0;
      busy_c    = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.req_valid) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            busy_c = 1'b1;
            if (idx == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy_c  = 1'b1;
            valid_c = 1'b1;
            if (bus.rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ULA_SEQ_ZERO_EN
   logic         zero_reg;
   logic [W-1:0] f_merged;

   // Result as it will look after the final byte lands, so the zero flag
   // is ready in the same edge that enters DONE.
   always_comb begin
      f_merged               = f_reg;
      f_merged[bit_off +: 8] = alu_f;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         s_reg    <= 4'd0;
         m_reg    <= 1'b0;
         idx      <= '0;
         carry    <= 1'b0;
         eq_acc   <= 1'b0;
         f_reg    <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
`ifdef ULA_SEQ_ZERO_EN
         zero_reg <= 1'b0;
`endif
      end else if (accept) begin
         a_reg  <= bus.req_a;
         b_reg  <= bus.req_b;
         s_reg  <= bus.req_s;
         m_reg  <= bus.req_m;
         idx    <= '0;
         carry  <= bus.req_cin;
         eq_acc <= 1'b1;
      end else if (state == EXEC) begin
         f_reg[bit_off +: 8] <= alu_f;
         carry               <= alu_cout;
         eq_acc              <= eq_acc & alu_eq;
         if (idx == LAST) begin
            cout_reg <= alu_cout;
            ovf_reg  <= alu_ovf;
`ifdef ULA_SEQ_ZERO_EN
            zero_reg <= (f_merged == '0);
`endif
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign bus.req_ready    = ready_c;
   assign bus.rsp_valid    = valid_c;
   assign bus.busy         = busy_c;
   assign bus.rsp_f        = f_reg;
   assign bus.rsp_eq       = eq_acc;
   assign bus.rsp_cout     = cout_reg;
   assign bus.rsp_overflow = ovf_reg;
`ifdef ULA_SEQ_ZERO_EN
   assign bus.rsp_zero     = zero_reg;
`endif

endmodule
